// File: rtl/decimator_pkg.sv
// Shared types and default sizing for the multichannel decimator.
package decimator_pkg;

   localparam int unsigned DefNumChannels       = 4;
   localparam int unsigned DefDataBits          = 10;
   localparam int unsigned DefMaxLog2Factor     = 4;
   localparam int unsigned DefDefaultLog2Factor = 3;
   localparam int unsigned AccBits              = DefDataBits + DefMaxLog2Factor;

   typedef enum logic {
      DEC_PICK = 1'b0,
      DEC_AVG  = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

endpackage

// File: rtl/multichannel_decimator_if.sv
// Sample-stream, output-stream and configuration signals of the decimator.
interface multichannel_decimator_if #(
   parameter int unsigned NumChannels   = 4,
   parameter int unsigned DataBits      = 10,
   parameter int unsigned MaxLog2Factor = 4
) ();
   localparam int unsigned KW = $clog2(MaxLog2Factor + 1);
   localparam int unsigned DW = NumChannels * DataBits;

   logic          cfg_load_i;
   logic [KW-1:0] cfg_log2_factor_i;
   logic          cfg_mode_i;
   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;

   modport slave (
      input  cfg_load_i, cfg_log2_factor_i, cfg_mode_i, data_i, valid_i, ready_i,
      output ready_o, data_o, valid_o
   );

   modport master (
      output cfg_load_i, cfg_log2_factor_i, cfg_mode_i, data_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o
   );
endinterface

// File: rtl/multichannel_decimator_lane.sv
// One lane: sign-extended group accumulator and PICK/AVG result select.
module decim_lane
   import decimator_pkg::*;
#(
   parameter int unsigned DataBits      = 10,
   parameter int unsigned MaxLog2Factor = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [DataBits-1:0]               i_sample,
   input  logic                              i_accept,
   input  logic                              i_wrap,
   input  logic                              i_clear,
   input  mode_e                             i_mode,
   input  logic [$clog2(MaxLog2Factor+1)-1:0] i_k,
   output logic [DataBits-1:0]               o_result_c
);
   localparam int unsigned AccW = DataBits + MaxLog2Factor;

   logic signed [AccW-1:0] r_acc;
   logic signed [AccW-1:0] w_sum;

   assign w_sum = r_acc + {{MaxLog2Factor{i_sample[DataBits-1]}}, i_sample};

   // Arithmetic shift floors toward -inf; low DataBits hold the mean.
   assign o_result_c = (i_mode == DEC_PICK) ? i_sample : DataBits'(w_sum >>> i_k);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_accept) begin
         r_acc <= i_wrap ? '0 : w_sum;
      end
   end
endmodule

// File: rtl/multichannel_decimator.sv
// Multichannel power-of-two decimator: shared counter, FSM, config and handshake.
module multichannel_decimator
   import decimator_pkg::*;
#(
   parameter int unsigned NumChannels       = DefNumChannels,
   parameter int unsigned DataBits          = DefDataBits,
   parameter int unsigned MaxLog2Factor     = DefMaxLog2Factor,
   parameter int unsigned DefaultLog2Factor = DefDefaultLog2Factor
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   multichannel_decimator_if.slave  bus
);
   localparam int unsigned KW = $clog2(MaxLog2Factor + 1);
   localparam int unsigned CW = MaxLog2Factor;
   localparam int unsigned DW = NumChannels * DataBits;

   logic [KW-1:0] r_k;
   mode_e         r_mode;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   logic          r_valid;
   logic [DW-1:0] r_data;

   logic [CW-1:0] w_mask;
   logic          w_wrap;
   logic          w_next_is_emit;
   logic          w_ready;
   logic          w_accept;
   logic          w_emit;
   logic [KW-1:0] w_k_clamped;
   logic [DW-1:0] w_lane_res;

   assign w_mask         = CW'((32'd1 << r_k) - 32'd1);
   assign w_wrap         = (r_cnt == w_mask);
   assign w_next_is_emit = (r_mode == DEC_PICK) ? (r_cnt == '0) : w_wrap;
   // Only an emit can be blocked; it needs the output register free or draining.
   assign w_ready        = !(w_next_is_emit && r_valid && !bus.ready_i);
   assign w_accept       = bus.valid_i && w_ready;
   assign w_emit         = w_accept && w_next_is_emit && !bus.cfg_load_i;
   assign w_k_clamped    = (bus.cfg_log2_factor_i > KW'(MaxLog2Factor)) ?
                           KW'(MaxLog2Factor) : bus.cfg_log2_factor_i;

   assign bus.ready_o = w_ready;
   assign bus.valid_o = r_valid;
   assign bus.data_o  = r_data;

   for (genvar c = 0; c < NumChannels; c++) begin : g_lane
      decim_lane #(
         .DataBits      (DataBits),
         .MaxLog2Factor (MaxLog2Factor)
      ) u_lane (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .i_sample   (bus.data_i[c*DataBits +: DataBits]),
         .i_accept   (w_accept),
         .i_wrap     (w_wrap),
         .i_clear    (bus.cfg_load_i),
         .i_mode     (r_mode),
         .i_k        (r_k),
         .o_result_c (w_lane_res[c*DataBits +: DataBits])
      );
   end

   // Config, group counter, control FSM and output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_k     <= KW'(DefaultLog2Factor);
         r_mode  <= DEC_PICK;
         r_cnt   <= '0;
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (bus.cfg_load_i) begin
            r_k     <= w_k_clamped;
            r_mode  <= mode_e'(bus.cfg_mode_i);
            r_cnt   <= '0;
            r_state <= IDLE;
         end else begin
            if (w_accept) begin
               r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            end
            case (r_state)
               IDLE:    if (w_accept) r_state <= RUN;
               RUN:     if (bus.valid_i && w_next_is_emit && r_valid && !bus.ready_i)
                           r_state <= STALL;
               STALL:   if (bus.ready_i) r_state <= RUN;
               default: r_state <= IDLE;
            endcase
         end

         if (w_emit) begin
            r_valid <= 1'b1;
            r_data  <= w_lane_res;
         end else if (r_valid && bus.ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/multichannel_decimator.md
# multichannel_decimator

Parametrised successor to the single-channel keep-every-nth decimator: NumChannels lanes of signed samples share one valid/ready input stream and are decimated by a runtime-selectable power-of-two factor. Two modes are supported. PICK keeps the first sample of each group. AVG outputs the truncated mean of each group. The block sits between the front-end sample stream and the compression stages, and its registered output supports backpressure from downstream.

## Interface
- NumChannels, 4: parallel lanes, all sharing valid/ready.
- DataBits, 10: signed two's-complement sample width per lane.
- MaxLog2Factor, 4: largest factor is 2^MaxLog2Factor; must be ≥1.
- DefaultLog2Factor, 3: factor exponent after reset.
- Reset: rst_ni is asynchronous, active-low; the clock is clk_i.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_load_i  in  1  single-cycle pulse that loads cfg_log2_factor_i and cfg_mode_i.
- cfg_log2_factor_i  in  $clog2(MaxLog2Factor+1)  factor exponent k; values above MaxLog2Factor are clamped to MaxLog2Factor.
- cfg_mode_i  in  1  0 = PICK, 1 = AVG.
- data_i  in  NumChannels*DataBits  lane c occupies bits [c*DataBits +: DataBits].
- valid_i  in  1  input sample valid.
- ready_o  out  1  input accepted when valid_i && ready_o.
- data_o  out  NumChannels*DataBits  decimated samples, same packing as data_i.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.

## Operation
- Factor N = 2^k, where k is the active exponent. Group counter cnt_q counts 0..N-1 and advances on each accepted sample, wrapping from N-1 to 0.
- Accumulators are per lane and DataBits+MaxLog2Factor bits wide, sign-extended, so they cannot overflow.
- Emit point:
  - PICK mode: an accepted sample with cnt_q==0. The output register loads that sample unchanged.
  - AVG mode: an accepted sample with cnt_q==N-1. The output register loads (acc + sample) >>> k, an arithmetic shift that truncates toward −∞, cut to DataBits. The accumulator clears in the same cycle.
- k=0 is pass-through in both modes: every sample is an emit point.
- FSM in a shared package, state_t {IDLE, RUN, STALL}:
  - IDLE → RUN on the first accepted sample.
  - RUN → STALL when the next accepted sample would be an emit point while valid_o && !ready_i.
  - STALL → RUN when ready_i is high.
  - Any state → IDLE on cfg_load_i.
- ready_o = !(next_is_emit && valid_o && !ready_i). Samples that are not emit points are always accepted.
- Output register: valid_o sets on an emit and clears on valid_o && ready_i unless a new emit occurs in the same cycle. Emit and drain in the same cycle is legal: the new data replaces the old and valid_o stays 1.
- data_o is stable while valid_o && !ready_i.
- cfg_load_i:
  - Applies k and mode from the next cycle.
  - Clears cnt_q and all accumulators, discarding any partial group. Samples accepted in the load cycle are also discarded.
  - Does not clear a pending output.
- Reset: all of the following take effect immediately and asynchronously:
  - valid_o=0, data_o=0.
  - ready_o=1; it is combinational and follows valid_o=0.
  - cnt_q=0, accumulators 0.
  - k=DefaultLog2Factor, mode=PICK, state=IDLE.
- Reset mid-group discards the group, and no output is produced for it.

## Timing
- Latency is one cycle: valid_o rises on the clock edge that accepts the emit-point sample.
- Maximum throughput is one output per N accepted inputs. With k=0, it is one output per cycle when ready_i is held high.
- ready_o depends combinationally on ready_i and registered state only. There is no path from valid_i to ready_o.
- Configuration registers update one cycle after the cfg_load_i edge.

## Structure
- Package decimator_pkg holds:
  - mode_e {DEC_PICK, DEC_AVG}
  - state_t
  - the localparam AccBits = DataBits+MaxLog2Factor.
- Sub-module decim_lane holds one lane's accumulator, shift and select logic. The top generates NumChannels instances and owns the counter, FSM, configuration and handshake.

## Test plan
- PICK mode, k=3, 1 lane, input ramp 0..31, ready_i=1: outputs 0, 8, 16, 24, each one cycle after its sample.
- AVG mode, k=2, samples −3, −2, 5, 1: sum is 1, so the output is 0. Samples −1, −1, −1, −2: sum is −5, so the output is −2 (truncation toward −∞).
- AVG mode, k=4, all samples = +511 (10 bits): output is +511, with no overflow. All samples = −512: output is −512.
- Backpressure: k=1, ready_i=0 for 6 cycles with valid_i=1:
  - ready_o drops at the next emit point.
  - data_o holds its value.
  - after ready_i=1, the drain and new emit occur in the same cycle with no sample lost.
- cfg_load_i after 5 of 8 samples (switching to AVG, k=1): the partial group is discarded, and the next output is the mean of the next 2 samples.
- Reset asserted mid-group with valid_o=1: valid_o=0 and data_o=0 immediately. After reset, PICK mode with k=3 is active and the first accepted sample is emitted.
